// File: rtl/elevator_dispatch.sv
// Collective (SCAN) car scheduler: walks a modelled car floor by floor, times door
// dwell and returns one-cycle clear pulses to the button-latch stage.
module elevator_dispatch #(
  parameter int FLOORS       = 8,
  parameter int TRAVEL_TICKS = 16,
  parameter int DOOR_TICKS   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] active_in_levels,
  input  logic [FLOORS-2:0] active_out_up_levels,
  input  logic [FLOORS-1:1] active_out_down_levels,
  output logic [FLOORS-1:0] inactivate_in_levels,
  output logic [FLOORS-2:0] inactivate_out_up_levels,
  output logic [FLOORS-1:1] inactivate_out_down_levels,
  output logic [3:0]        buttons_blocked,
  output logic [3:0]        current_floor,
  output logic [1:0]        direction,
  output logic              door_open,
  output logic              moving,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam int TW = $clog2(TRAVEL_TICKS + 1);
  localparam int DW = $clog2(DOOR_TICKS + 1);
  localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_TICKS - 1);
  localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_TICKS);
  localparam logic [3:0]    TOP_FLOOR   = 4'(FLOORS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, DOOR = 2'd2} state_t;

  state_t          state;
  logic [TW-1:0]   travel_cnt;
  logic [DW-1:0]   door_cnt;
  logic            arrived;

  assign state_dbg = state;

  // Hall vectors widened to full floor range so every floor indexes uniformly.
  logic [FLOORS-1:0] up_full, dn_full, any_req, here_mask;
  logic [FLOORS-1:0] prev_up, prev_dn;
  logic [FLOORS-1:0] clr_in, clr_up, clr_dn;
  logic [FLOORS-1:0] ent_up, ent_dn, dwl_up, dwl_dn, rev_up, rev_dn;
  logic              above, below, here_in, here_up, here_dn, here;
  logic              stop_here, ahead, behind, new_here;
  logic [1:0]        entry_dir, rev_dir;

  // Clear pulses are a one-cycle strobe per latched bit; a bit pulsed last cycle
  // is masked so the upstream edge detector never sees two back-to-back pulses.
  always_comb begin
    up_full = '0;
    dn_full = '0;
    prev_up = '0;
    prev_dn = '0;
    up_full[FLOORS-2:0] = active_out_up_levels;
    dn_full[FLOORS-1:1] = active_out_down_levels;
    prev_up[FLOORS-2:0] = inactivate_out_up_levels;
    prev_dn[FLOORS-1:1] = inactivate_out_down_levels;
    any_req = active_in_levels | up_full | dn_full;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i > int'(current_floor)) above = above | any_req[i];
      if (i < int'(current_floor)) below = below | any_req[i];
    end
    here_mask = FLOORS'(1) << current_floor;
    here_in   = |(here_mask & active_in_levels);
    here_up   = |(here_mask & up_full);
    here_dn   = |(here_mask & dn_full);
    here      = here_in | here_up | here_dn;
    clr_in    = here_mask & active_in_levels & ~inactivate_in_levels;
    clr_up    = here_mask & up_full & ~prev_up;
    clr_dn    = here_mask & dn_full & ~prev_dn;

    case (direction)
      DIR_UP:   entry_dir = (here_up | above) ? DIR_UP : DIR_DOWN;
      DIR_DOWN: entry_dir = (here_dn | below) ? DIR_DOWN : DIR_UP;
      default:  entry_dir = DIR_NONE;
    endcase
    case (direction)
      DIR_UP:   rev_dir = DIR_DOWN;
      DIR_DOWN: rev_dir = DIR_UP;
      default:  rev_dir = DIR_NONE;
    endcase

    ent_up = (entry_dir != DIR_DOWN) ? clr_up : '0;
    ent_dn = (entry_dir != DIR_UP)   ? clr_dn : '0;
    dwl_up = (direction != DIR_DOWN) ? clr_up : '0;
    dwl_dn = (direction != DIR_UP)   ? clr_dn : '0;
    rev_up = (rev_dir != DIR_DOWN)   ? clr_up : '0;
    rev_dn = (rev_dir != DIR_UP)     ? clr_dn : '0;
    new_here = (|clr_in) | (|dwl_up) | (|dwl_dn);

    // Stopping when nothing lies beyond also covers opposite-direction hall
    // calls at the last useful floor and requests vanishing mid-travel.
    if (direction == DIR_UP) begin
      stop_here = here_in | here_up | ~above | (current_floor == TOP_FLOOR);
      ahead     = above;
      behind    = below;
    end else if (direction == DIR_DOWN) begin
      stop_here = here_in | here_dn | ~below | (current_floor == 4'd0);
      ahead     = below;
      behind    = above;
    end else begin
      stop_here = 1'b1;
      ahead     = 1'b0;
      behind    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                      <= IDLE;
      current_floor              <= 4'd0;
      direction                  <= DIR_NONE;
      door_open                  <= 1'b0;
      moving                     <= 1'b0;
      buttons_blocked            <= 4'h0;
      inactivate_in_levels       <= '0;
      inactivate_out_up_levels   <= '0;
      inactivate_out_down_levels <= '0;
      travel_cnt                 <= '0;
      door_cnt                   <= '0;
      arrived                    <= 1'b0;
    end else begin
      inactivate_in_levels       <= '0;
      inactivate_out_up_levels   <= '0;
      inactivate_out_down_levels <= '0;
      case (state)
        IDLE: begin
          if (here) begin
            state                      <= DOOR;
            door_open                  <= 1'b1;
            door_cnt                   <= DOOR_LOAD;
            buttons_blocked            <= current_floor;
            inactivate_in_levels       <= clr_in;
            inactivate_out_up_levels   <= ent_up[FLOORS-2:0];
            inactivate_out_down_levels <= ent_dn[FLOORS-1:1];
          end else if (above | below) begin
            state           <= MOVE;
            moving          <= 1'b1;
            buttons_blocked <= 4'hF;
            travel_cnt      <= TRAVEL_LOAD;
            arrived         <= 1'b0;
            direction       <= above ? DIR_UP : DIR_DOWN;
          end
        end

        MOVE: begin
          if (arrived) begin
            arrived <= 1'b0;
            if (stop_here) begin
              state                      <= DOOR;
              moving                     <= 1'b0;
              door_open                  <= 1'b1;
              door_cnt                   <= DOOR_LOAD;
              buttons_blocked            <= current_floor;
              direction                  <= entry_dir;
              inactivate_in_levels       <= clr_in;
              inactivate_out_up_levels   <= ent_up[FLOORS-2:0];
              inactivate_out_down_levels <= ent_dn[FLOORS-1:1];
            end else begin
              // The decision cycle doubles as the first tick of the next hop.
              travel_cnt <= travel_cnt - 1'b1;
            end
          end else if (travel_cnt == '0) begin
            current_floor <= (direction == DIR_DOWN) ? current_floor - 4'd1
                                                     : current_floor + 4'd1;
            travel_cnt    <= TRAVEL_LOAD;
            arrived       <= 1'b1;
          end else begin
            travel_cnt <= travel_cnt - 1'b1;
          end
        end

        DOOR: begin
          if (new_here) begin
            door_cnt                   <= DOOR_LOAD;
            inactivate_in_levels       <= clr_in;
            inactivate_out_up_levels   <= dwl_up[FLOORS-2:0];
            inactivate_out_down_levels <= dwl_dn[FLOORS-1:1];
          end else if (door_cnt == DW'(1)) begin
            if (ahead | behind) begin
              state           <= MOVE;
              door_open       <= 1'b0;
              moving          <= 1'b1;
              buttons_blocked <= 4'hF;
              travel_cnt      <= TRAVEL_LOAD;
              arrived         <= 1'b0;
              if (!ahead) direction <= rev_dir;
            end else if (here && direction != DIR_NONE) begin
              // Pending opposite call at this floor: reopen serving the other way.
              direction                  <= rev_dir;
              door_cnt                   <= DOOR_LOAD;
              inactivate_in_levels       <= clr_in;
              inactivate_out_up_levels   <= rev_up[FLOORS-2:0];
              inactivate_out_down_levels <= rev_dn[FLOORS-1:1];
            end else begin
              state     <= IDLE;
              door_open <= 1'b0;
              direction <= DIR_NONE;
            end
          end else begin
            door_cnt <= door_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
